// File: rtl/mips_cache_arbiter.sv
// rtl/mips_cache_arbiter.sv - shares one Avalon-MM memory port between the I-cache and D-cache miss paths
// One transaction at a time: grant in IDLE, run the bus transfer in BUS, pulse valid in RESP.
module mips_cache_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int D_PRIORITY = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [31:0]       i_data,
   output logic              i_valid,
   input  logic              d_req,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   input  logic [3:0]        d_byteen,
   output logic [31:0]       d_data,
   output logic              d_valid,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_read,
   output logic              mem_write,
   output logic [31:0]       mem_writedata,
   output logic [3:0]        mem_byteenable,
   input  logic              mem_waitrequest,
   input  logic [31:0]       mem_readdata,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t            state, state_nx;
   logic              owner;       // 1 = data cache owns the current transaction
   logic              last_grant;  // 1 = data cache was granted last
   logic              is_write;
   logic              grant, grant_d;
   logic [ADDR_W-1:0] sel_addr;

   always_comb begin
      state_nx = state;
      grant    = 1'b0;
      grant_d  = 1'b0;
      case (state)
         IDLE: begin
            if (i_req || d_req) begin
               grant    = 1'b1;
               state_nx = BUS;
               if (i_req && d_req)
                  grant_d = (D_PRIORITY != 0) ? 1'b1 : !last_grant;
               else
                  grant_d = d_req;
            end
         end
         BUS:     if (!mem_waitrequest) state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign sel_addr  = grant_d ? d_addr : i_addr;
   assign mem_read  = (state == BUS) && !is_write;
   assign mem_write = (state == BUS) && is_write;
   assign busy      = (state != IDLE);
   // A requester that withdrew during BUS gets no pulse; the transfer itself is never aborted.
   assign i_valid   = (state == RESP) && !owner && i_req;
   assign d_valid   = (state == RESP) && owner && d_req;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         owner          <= 1'b0;
         last_grant     <= 1'b1;
         is_write       <= 1'b0;
         mem_address    <= '0;
         mem_writedata  <= '0;
         mem_byteenable <= 4'b0000;
         i_data         <= '0;
         d_data         <= '0;
      end else begin
         state <= state_nx;
         if (grant) begin
            owner       <= grant_d;
            last_grant  <= grant_d;
            is_write    <= grant_d && d_write;
            mem_address <= sel_addr & ~ADDR_W'(3);
            if (grant_d && d_write) begin
               mem_writedata  <= d_wdata;
               mem_byteenable <= d_byteen;
            end else begin
               mem_byteenable <= 4'b1111;
            end
         end
         if (state == BUS && !mem_waitrequest && !is_write) begin
            if (owner) d_data <= mem_readdata;
            else       i_data <= mem_readdata;
         end
      end
   end

endmodule
